dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 118 +++++++++++
 tb/tb_dmem_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin data memory arbiter with lock, size legality checking and read-data extension.
module dmem_arbiter #(
    parameter int LOCK_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [1:0]  size0,
    input  logic [1:0]  size1,
    input  logic        lock0,
    input  logic        lock1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rdata,
    output logic        busy,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic        mem_byte,
    output logic        mem_halfword,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ISSUE, READ, RESP} state_t;
    localparam logic [3:0] LMAX = 4'(LOCK_MAX);
    state_t      state;
    logic        last, sel, we_r, legal_r;
    logic [1:0]  size_r;
    logic [3:0]  cnt;
    logic        lock_last, win, s_we, s_legal;
    logic [1:0]  s_size;
    logic [31:0] s_addr, s_wdata, ext;
    always_comb begin
        lock_last = last ? lock1 : lock0;
        // a locked last-served requester keeps the grant until it has had LOCK_MAX in a row
        win       = (req0 && req1) ? ((lock_last && cnt < LMAX) ? last : ~last) : req1;
        s_we      = win ? we1 : we0;
        s_size    = win ? size1 : size0;
        s_addr    = win ? addr1 : addr0;
        s_wdata   = win ? wdata1 : wdata0;
        s_legal   = !(s_size == 2'b11 || (s_size == 2'b01 && s_addr[0]) ||
                      (s_size == 2'b00 && s_addr[1:0] != 2'b00));
        ext       = size_r == 2'b10 ? {24'b0, mem_rdata[7:0]} :
                    size_r == 2'b01 ? {16'b0, mem_rdata[15:0]} : mem_rdata;
    end
    assign mem_we = (state == ISSUE) && we_r && legal_r && !reset;
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            last         <= 1'b1;
            cnt          <= 4'd0;
            sel          <= 1'b0;
            we_r         <= 1'b0;
            legal_r      <= 1'b0;
            size_r       <= 2'b00;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            err0         <= 1'b0;
            err1         <= 1'b0;
            busy         <= 1'b0;
            rdata        <= 32'd0;
            mem_addr     <= 32'd0;
            mem_wdata    <= 32'd0;
            mem_byte     <= 1'b0;
            mem_halfword <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req0 || req1) begin
                    state        <= ISSUE;
                    busy         <= 1'b1;
                    sel          <= win;
                    last         <= win;
                    cnt          <= (win == last) ? (cnt < LMAX ? cnt + 4'd1 : cnt) : 4'd1;
                    we_r         <= s_we;
                    size_r       <= s_size;
                    legal_r      <= s_legal;
                    mem_addr     <= s_addr;
                    mem_wdata    <= s_wdata;
                    mem_byte     <= s_size == 2'b10;
                    mem_halfword <= s_size == 2'b01;
                end
                ISSUE: if (!we_r && legal_r) begin
                    state <= READ;
                end else begin
                    state <= RESP;
                    ack0  <= ~sel;
                    ack1  <= sel;
                    err0  <= ~sel & ~legal_r;
                    err1  <= sel & ~legal_r;
                    rdata <= 32'd0;
                end
                READ: begin
                    state <= RESP;
                    ack0  <= ~sel;
                    ack1  <= sel;
                    rdata <= ext;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    err0  <= 1'b0;
                    err1  <= 1'b0;
                    rdata <= 32'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors and arbitration sequences against a word-indexed memory model.
module tb_dmem_arbiter;
    logic clk = 0, reset = 1;
    logic req0 = 0, req1 = 0, we0 = 0, we1 = 0, lock0 = 0, lock1 = 0;
    logic [1:0] size0 = 0, size1 = 0;
    logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
    logic ack0, ack1, err0, err1, busy, mem_we, mem_byte, mem_halfword;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic [31:0] mem [0:63];
    int wcnt = 0, tests = 0, fails = 0;
    always #5 clk = ~clk;
    dmem_arbiter #(.LOCK_MAX(4)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .size0(size0), .size1(size1), .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1), .rdata(rdata), .busy(busy),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_byte(mem_byte), .mem_halfword(mem_halfword),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );
    always @(posedge clk) begin
        if (mem_we) begin
            wcnt <= wcnt + 1;
            if (mem_byte) mem[mem_addr[7:2]][7:0] <= mem_wdata[7:0];
            else if (mem_halfword) mem[mem_addr[7:2]][15:0] <= mem_wdata[15:0];
            else mem[mem_addr[7:2]] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr[7:2]];
    end
    typedef struct {
        logic p, we;
        logic [1:0] sz;
        logic [31:0] a, d, rd;
        logic er;
        int lat, wr;
        logic [1:0] bh;
    } vec_t;
    vec_t v[12];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic chk_reset_state(input string name);
        chk({name, "_ctl"}, {24'd0, ack0, ack1, err0, err1, busy, mem_we, mem_byte, mem_halfword}, 32'd0);
        chk({name, "_rdata"}, rdata, 32'd0);
        chk({name, "_maddr"}, mem_addr, 32'd0);
        chk({name, "_mwdata"}, mem_wdata, 32'd0);
    endtask
    task automatic do_reset();
        reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
    endtask
    task automatic txn(input logic p, input logic we, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, output int lat, output logic [31:0] rd,
                       output logic er, output logic oth, output logic [1:0] bh);
        lat = 0; rd = '1; er = 0; oth = 0; bh = 0;
        if (p) begin req1 = 1; we1 = we; size1 = sz; addr1 = a; wdata1 = d; end
        else   begin req0 = 1; we0 = we; size0 = sz; addr0 = a; wdata0 = d; end
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) bh = {mem_byte, mem_halfword};
            if (p ? ack0 : ack1) oth = 1;
            if (p ? ack1 : ack0) begin
                lat = n; rd = rdata; er = p ? err1 : err0;
                break;
            end
        end
        req0 = 0; req1 = 0;
        @(negedge clk);
    endtask
    task automatic collect(input int n, output logic [7:0] ord, output int got);
        ord = 0; got = 0;
        for (int c = 0; c < 200 && got < n; c++) begin
            @(negedge clk);
            if (ack0 || ack1) begin ord = {ord[6:0], ack1}; got++; end
        end
    endtask
    initial begin
        int lat, got, w0;
        logic [31:0] rd;
        logic er, oth, noack;
        logic [1:0] bh;
        logic [7:0] ord;
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        v[0]  = '{0, 1, 2'b00, 32'h10, 32'hDEADBEEF, 32'h0,        0, 2, 1, 2'b00};
        v[1]  = '{1, 0, 2'b00, 32'h10, 32'h0,        32'hDEADBEEF, 0, 3, 0, 2'b00};
        v[2]  = '{0, 1, 2'b00, 32'h10, 32'hAABBCCDD, 32'h0,        0, 2, 1, 2'b00};
        v[3]  = '{0, 0, 2'b10, 32'h13, 32'h0,        32'h000000DD, 0, 3, 0, 2'b10};
        v[4]  = '{0, 0, 2'b01, 32'h11, 32'h0,        32'h0,        1, 2, 0, 2'b01};
        v[5]  = '{1, 0, 2'b01, 32'h12, 32'h0,        32'h0000CCDD, 0, 3, 0, 2'b01};
        v[6]  = '{1, 1, 2'b11, 32'h10, 32'h12345678, 32'h0,        1, 2, 0, 2'b00};
        v[7]  = '{0, 0, 2'b00, 32'h10, 32'h0,        32'hAABBCCDD, 0, 3, 0, 2'b00};
        v[8]  = '{1, 1, 2'b00, 32'h12, 32'h55667788, 32'h0,        1, 2, 0, 2'b00};
        v[9]  = '{0, 1, 2'b10, 32'h21, 32'h00000055, 32'h0,        0, 2, 1, 2'b10};
        v[10] = '{1, 0, 2'b00, 32'h20, 32'h0,        32'h00000055, 0, 3, 0, 2'b00};
        v[11] = '{1, 0, 2'b11, 32'h24, 32'h0,        32'h0,        1, 2, 0, 2'b00};
        @(negedge clk);
        @(negedge clk);
        chk_reset_state("reset0");
        reset = 0;
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            w0 = wcnt;
            txn(v[i].p, v[i].we, v[i].sz, v[i].a, v[i].d, lat, rd, er, oth, bh);
            chk($sformatf("v%0d_lat", i), lat, v[i].lat);
            chk($sformatf("v%0d_rdata", i), rd, v[i].rd);
            chk($sformatf("v%0d_err", i), {31'd0, er}, {31'd0, v[i].er});
            chk($sformatf("v%0d_other_ack", i), {31'd0, oth}, 32'd0);
            chk($sformatf("v%0d_writes", i), wcnt - w0, v[i].wr);
            chk($sformatf("v%0d_size_out", i), {30'd0, bh}, {30'd0, v[i].bh});
        end
        w0 = wcnt;
        req0 = 1; we0 = 1; size0 = 0; addr0 = 32'h10; wdata0 = 32'h11111111;
        @(negedge clk);
        chk("rst_pre_we", {31'd0, mem_we}, 32'd1);
        reset = 1;
        #1 chk("rst_we_low", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk_reset_state("reset1");
        reset = 0; req0 = 0;
        noack = 0;
        repeat (4) begin @(negedge clk); if (ack0 || ack1 || err0 || err1) noack = 1; end
        chk("rst_no_ack", {31'd0, noack}, 32'd0);
        chk("rst_no_write", wcnt - w0, 32'd0);
        chk("rst_mem_kept", mem[4], 32'hAABBCCDD);
        we0 = 0; we1 = 0; size0 = 0; size1 = 0; addr0 = 32'h10; addr1 = 32'h10;
        do_reset();
        req0 = 1; req1 = 1;
        collect(4, ord, got);
        req0 = 0; req1 = 0;
        chk("rr_got", got, 4);
        chk("rr_order", {24'd0, ord}, 32'h05);
        do_reset();
        lock1 = 1; req1 = 1;
        @(negedge clk);
        req0 = 1;
        collect(5, ord, got);
        req0 = 0; req1 = 0; lock1 = 0;
        chk("lock1_got", got, 5);
        chk("lock1_order", {24'd0, ord}, 32'h1E);
        do_reset();
        lock0 = 1; req0 = 1;
        collect(6, ord, got);
        chk("lock0_solo_got", got, 6);
        chk("lock0_solo_order", {24'd0, ord}, 32'h00);
        req1 = 1;
        collect(2, ord, got);
        req0 = 0; req1 = 0; lock0 = 0;
        chk("lock0_sat_got", got, 2);
        chk("lock0_sat_order", {24'd0, ord}, 32'h02);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
